mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Single-clock arbiter that shares one single-port instruction/data memory between the fetch stage and the memory read/write stage of the 5-stage MIPS32 pipeline.
- Accepts one request per cycle and keeps at most one read outstanding.
- Routes read data back to the owning requester.
- Honours branch flush and halt, and reports busy so the pipeline control path can stall.

Parameters:
- DW, 32, data word width.
- AW, 32, address width. Word addressing, matching the PC+1 scheme.
- RD_LATENCY, 1, cycles from address sample to valid mem_rddata. Legal range 1..15.
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits. Used only with STARVE_GUARD_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_flush  in  1  branch taken; discard any outstanding or same-cycle fetch return.
- halt  in  1  blocks new fetch grants; data port still served.
- if_gnt  out  1  combinational; fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DW  registered fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  combinational; data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid.
- d_rdata  out  DW  registered load data.
- mem_addr  out  AW  memory address; combinational from the granted requester, 0 when no grant.
- mem_wdata  out  DW  equals d_wdata on a store grant, else 0.
- mem_wren  out  1  high only in a store grant cycle.
- mem_rddata  in  DW  memory read data, valid RD_LATENCY cycles after the address cycle.
- busy  out  1  registered; high while a read is outstanding.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FSM in IDLE, all registered outputs 0, if_rdata = d_rdata = 0, streak counter 0, latency counter 0, owner/drop flags 0.
- Reset mid-read: the outstanding read is abandoned and no rvalid is produced for it.
- FSM states:
  - IDLE: arbitrate.
    - Grant priority: data over fetch, since data belongs to the older instruction.
    - Fetch is not granted while halt = 1.
    - At most one gnt per cycle.
  - Store grant (cycle N): mem_wren = 1 in cycle N. FSM stays IDLE, so another grant is possible in N+1. No rvalid is produced.
  - Read grant (cycle N): FSM goes to WAIT. Owner is recorded and the latency counter is loaded with RD_LATENCY.
  - WAIT:
    - No grants. The counter decrements each cycle.
    - In cycle N+RD_LATENCY, mem_rddata is captured into the owner's rdata register.
    - In cycle N+RD_LATENCY+1 the owner's rvalid pulses and the FSM returns to IDLE.
    - A new grant is legal in that same cycle (back-to-back reads).
- Read throughput: one read per RD_LATENCY+1 cycles.
- busy: high from N+1 through N+RD_LATENCY inclusive.
- Flush:
  - if_flush in any cycle from the fetch grant through the capture cycle sets a drop flag.
  - With the drop flag set, if_rvalid stays 0 and if_rdata is not updated.
  - The FSM timing is unchanged.
  - if_flush in a cycle with a pending if_req suppresses that cycle's if_gnt.
- if_flush does not affect the data port.
- if_rdata and d_rdata hold their last captured value between pulses.
- Simultaneous if_req and d_req with halt = 1: data is granted, and fetch remains pending.
- Requests deasserted without a grant are not an error; the arbiter keeps no memory of them.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - A 4-bit streak counter increments on each data grant issued while if_req = 1 and halt = 0.
  - It clears on any fetch grant, or when if_req = 0.
  - When the counter reaches MAX_STREAK, the next IDLE arbitration with both requesting grants fetch, and the counter then clears.
- Not defined: strict data-over-fetch priority; the counter logic is absent.

Test Plan:
- Reset, then if_req with if_addr = 0x10 and mem_rddata = 0xA5A5_0001 (RD_LATENCY = 1) -> if_gnt in cycle 0, if_rvalid in cycle 2 with if_rdata = 0xA5A5_0001, busy high in cycle 1 only.
- if_req and d_req (store, d_addr = 0x20, d_wdata = 0x55) in the same cycle -> d_gnt, mem_wren = 1, mem_addr = 0x20, mem_wdata = 0x55; if_gnt the next cycle.
- Fetch read granted, if_flush in cycle 1, RD_LATENCY = 3 -> if_rvalid never asserts, if_rdata unchanged; a new grant is possible in cycle 4.
- halt = 1 with if_req and d_req (load 0x30) -> only d_gnt; d_rvalid at N+RD_LATENCY+1; if_gnt stays 0 until halt = 0.
- STARVE_GUARD_EN, MAX_STREAK = 2, continuous d_req stores and if_req -> grant order D, D, F, D, D, F. Without the macro -> D only.
- rst asserted during WAIT of a load -> no d_rvalid, all outputs 0 the next cycle, and a new grant is accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake and memory bus between the pipeline
// requesters (fetch, data), the arbiter and the single-port memory.
//   slave  modport : arbiter side (takes requests, drives grants/returns/memory)
//   master modport : pipeline/memory side (drives requests and mem_rddata)
// Parameters DW/AW must match the arbiter instance.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          halt;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  // memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rddata;
  // pipeline stall hint
  logic          busy;

  modport slave (
    input  if_req, if_addr, if_flush, halt,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rddata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_wren,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush, halt,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rddata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between
// the fetch stage and the memory stage of the MIPS32 pipeline.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave
//          fetch  : if_req/if_addr/if_flush/halt in, if_gnt/if_rvalid/if_rdata out
//          data   : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//          memory : mem_addr/mem_wdata/mem_wren out, mem_rddata in
//          busy   : registered, high while a read is outstanding
// Data wins arbitration over fetch (older instruction). Stores complete in
// the grant cycle; reads hold the port for RD_LATENCY cycles and return on
// a one-cycle rvalid pulse to the owner.
// Optional: define STARVE_GUARD_EN to let fetch in after MAX_STREAK
// consecutive data grants taken while fetch was waiting.
module mem_port_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_lat
    $error("RD_LATENCY must be 1..15");
  end
  if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
    $error("MAX_STREAK must be 1..15");
  end

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    lat_cnt;
  logic          owner_d;   // 1: outstanding read belongs to data port
  logic          drop;      // fetch return discarded by a flush
  logic          busy_q;
  logic          if_rvalid_q, d_rvalid_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic          fetch_ok, starve, gnt_d, gnt_f;
`ifdef STARVE_GUARD_EN
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  logic [3:0]    streak;
`endif

  // Arbitration. A flush in the request cycle kills that cycle's fetch
  // grant, so the fetch address that lost the branch never reaches memory.
  always_comb begin
    fetch_ok = bus.if_req & ~bus.halt & ~bus.if_flush;
    starve   = 1'b0;
`ifdef STARVE_GUARD_EN
    starve   = fetch_ok & (streak >= STREAK_MAX);
`endif
    gnt_d    = ~rst & (state == S_IDLE) & bus.d_req & ~starve;
    gnt_f    = ~rst & (state == S_IDLE) & fetch_ok & ~gnt_d;
  end

  assign bus.d_gnt     = gnt_d;
  assign bus.if_gnt    = gnt_f;
  assign bus.mem_addr  = gnt_d ? bus.d_addr : (gnt_f ? bus.if_addr : '0);
  assign bus.mem_wren  = gnt_d & bus.d_we;
  assign bus.mem_wdata = (gnt_d & bus.d_we) ? bus.d_wdata : '0;
  assign bus.busy      = busy_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      owner_d     <= 1'b0;
      drop        <= 1'b0;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          // stores finish in the grant cycle; only reads occupy the port
          if ((gnt_d & ~bus.d_we) | gnt_f) begin
            state   <= S_WAIT;
            lat_cnt <= LAT;
            owner_d <= gnt_d;
            drop    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (~owner_d & bus.if_flush) drop <= 1'b1;
          if (lat_cnt == 4'd1) begin
            // capture cycle: mem_rddata is valid now
            state  <= S_IDLE;
            busy_q <= 1'b0;
            if (owner_d) begin
              d_rdata_q  <= bus.mem_rddata;
              d_rvalid_q <= 1'b1;
            end else if (~(drop | bus.if_flush)) begin
              if_rdata_q  <= bus.mem_rddata;
              if_rvalid_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STARVE_GUARD_EN
  // Counts data grants taken while fetch was eligible-but-waiting; saturates.
  always_ff @(posedge clk) begin
    if (rst)                         streak <= '0;
    else if (gnt_f | ~bus.if_req)    streak <= '0;
    else if (gnt_d & ~bus.halt & (streak != 4'hF))
                                     streak <= streak + 4'd1;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, L = 3, MS = 2;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus();

  mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LATENCY(L), .MAX_STREAK(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk);     endtask

  task automatic clr();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0; bus.halt = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr(); bus.mem_rddata = 32'hFFFF_FFFF;
    tick(); tick(); sample();
    vectors++;
    if ({bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_wren,
         bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b ifv=%b dv=%b ifr=%h dr=%h, want all 0",
                         bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata);
    end
    tick(); rst = 1'b0;
  endtask

  // Fetch read: grant in cycle 0, busy cycles 1..L, rvalid in L+1.
  task automatic test_fetch_read();
    clr(); bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.mem_rddata = 32'h0;
    sample(); vectors++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wren !== 1'b0) begin
      errors++; $display("FAIL fetch_grant: gnt=%b addr=%h wren=%b, want 1 10 0", bus.if_gnt, bus.mem_addr, bus.mem_wren);
    end
    tick();
    for (int c = 1; c <= L + 2; c++) begin
      clr(); bus.mem_rddata = (c == L) ? 32'hA5A5_0001 : 32'(c);
      sample(); vectors++;
      if (bus.busy !== (c <= L) || bus.if_rvalid !== (c == L + 1)) begin
        errors++; $display("FAIL fetch_timing c%0d: busy=%b rvalid=%b, want %b %b", c, bus.busy, bus.if_rvalid, c <= L, c == L + 1);
      end
      if (c >= L + 1) begin
        vectors++;
        if (bus.if_rdata !== 32'hA5A5_0001) begin
          errors++; $display("FAIL fetch_rdata c%0d: got %h want a5a50001", c, bus.if_rdata);
        end
      end
      tick();
    end
  endtask

  // Store and fetch together: store wins, fetch next cycle.
  task automatic test_store_prio();
    clr(); bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
    sample(); vectors++;
    if ({bus.d_gnt, bus.if_gnt, bus.mem_wren} !== 3'b101 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h55) begin
      errors++; $display("FAIL store_grant: dg=%b ig=%b wren=%b addr=%h wdata=%h, want 1 0 1 20 55",
                         bus.d_gnt, bus.if_gnt, bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    sample(); vectors++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h44 || bus.mem_wren !== 1'b0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL fetch_after_store: gnt=%b addr=%h wren=%b, want 1 44 0", bus.if_gnt, bus.mem_addr, bus.mem_wren);
    end
    tick();
    for (int c = 1; c <= L + 1; c++) begin
      clr(); bus.mem_rddata = 32'h1111_2222;
      sample();
      if (c == L + 1) begin
        vectors++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1111_2222 || bus.d_rvalid !== 1'b0) begin
          errors++; $display("FAIL fetch2_return: rv=%b rdata=%h drv=%b, want 1 11112222 0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    clr(); bus.if_req = 1'b1; bus.if_flush = 1'b1; bus.if_addr = 32'h7C;
    sample(); vectors++;
    if (bus.if_gnt !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL flush_same_cycle: gnt=%b addr=%h, want 0 0", bus.if_gnt, bus.mem_addr);
    end
    tick();
    clr(); bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.mem_rddata = 32'hDEAD_0000;
    sample(); vectors++;
    if (bus.if_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_grant: gnt=%b want 1", bus.if_gnt);
    end
    tick();
    for (int c = 1; c <= L + 1; c++) begin
      clr(); bus.if_flush = (c == 1);
      if (c == L + 1) begin bus.d_req = 1'b1; bus.d_addr = 32'h90; end
      sample(); vectors++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h1111_2222 || bus.busy !== (c <= L)) begin
        errors++; $display("FAIL flush_drop c%0d: rv=%b rdata=%h busy=%b, want 0 11112222 %b", c, bus.if_rvalid, bus.if_rdata, bus.busy, c <= L);
      end
      if (c == L + 1) begin
        vectors++;
        if (bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h90) begin
          errors++; $display("FAIL flush_next_grant: dg=%b addr=%h, want 1 90", bus.d_gnt, bus.mem_addr);
        end
      end
      tick();
    end
    // flush must not touch the data return
    for (int c = 1; c <= L + 1; c++) begin
      clr(); bus.if_flush = 1'b1;
      sample();
      if (c == L + 1) begin
        vectors++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_0000 || bus.if_rvalid !== 1'b0) begin
          errors++; $display("FAIL flush_data_return: drv=%b dr=%h irv=%b, want 1 dead0000 0", bus.d_rvalid, bus.d_rdata, bus.if_rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    clr(); bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h34;
    bus.d_req = 1'b1; bus.d_addr = 32'h30; bus.mem_rddata = 32'h3030_3030;
    sample(); vectors++;
    if ({bus.d_gnt, bus.if_gnt} !== 2'b10 || bus.mem_addr !== 32'h30) begin
      errors++; $display("FAIL halt_grant: dg=%b ig=%b addr=%h, want 1 0 30", bus.d_gnt, bus.if_gnt, bus.mem_addr);
    end
    tick();
    for (int c = 1; c <= L + 3; c++) begin
      bus.d_req = 1'b0;
      sample(); vectors++;
      if (bus.if_gnt !== 1'b0 || bus.d_rvalid !== (c == L + 1)) begin
        errors++; $display("FAIL halt_wait c%0d: ig=%b drv=%b, want 0 %b", c, bus.if_gnt, bus.d_rvalid, c == L + 1);
      end
      if (c == L + 1) begin
        vectors++;
        if (bus.d_rdata !== 32'h3030_3030) begin
          errors++; $display("FAIL halt_load_data: got %h want 30303030", bus.d_rdata);
        end
      end
      tick();
    end
    bus.halt = 1'b0;
    sample(); vectors++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h34) begin
      errors++; $display("FAIL halt_release: ig=%b addr=%h, want 1 34", bus.if_gnt, bus.mem_addr);
    end
    tick();
    clr();
    for (int c = 1; c <= L + 1; c++) tick();
  endtask

  task automatic test_streak();
    byte got[6];
    byte want[6];
    int  n = 0;
`ifdef STARVE_GUARD_EN
    want = '{"D", "D", "F", "D", "D", "F"};
`else
    want = '{"D", "D", "D", "D", "D", "D"};
`endif
    for (int i = 0; i < 6; i++) got[i] = "?";
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      clr(); bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'(cyc);
      sample();
      vectors++;
      if (bus.d_gnt && bus.if_gnt) begin
        errors++; $display("FAIL streak_one_gnt: both grants high in cycle %0d", cyc);
      end
      if (bus.d_gnt) begin got[n] = "D"; n++; end
      else if (bus.if_gnt) begin got[n] = "F"; n++; end
      tick();
    end
    vectors++;
    if (n < 6) begin
      errors++; $display("FAIL streak_timeout: %0d grants seen, want 6", n);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL streak_order[%0d]: got %c want %c", i, got[i], want[i]);
      end
    end
    clr();
    for (int c = 0; c <= L + 1; c++) tick();
  endtask

  task automatic test_reset_mid_read();
    clr(); bus.d_req = 1'b1; bus.d_addr = 32'h50; bus.mem_rddata = 32'h5555_AAAA;
    sample(); vectors++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_grant: dg=%b want 1", bus.d_gnt);
    end
    tick();
    clr(); sample(); vectors++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got %b want 1", bus.busy);
    end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    sample(); vectors++;
    if ({bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_wren,
         bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: busy=%b ifv=%b dv=%b ifr=%h dr=%h, want all 0",
                         bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h60; bus.d_wdata = 32'h7;
    sample(); vectors++;
    if (bus.d_gnt !== 1'b1 || bus.mem_wren !== 1'b1 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_regrant: dg=%b wren=%b drv=%b, want 1 1 0", bus.d_gnt, bus.mem_wren, bus.d_rvalid);
    end
    tick();
    for (int c = 0; c < L + 2; c++) begin
      clr(); sample(); vectors++;
      if (bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_return c%0d: drv=%b busy=%b, want 0 0", c, bus.d_rvalid, bus.busy);
      end
      tick();
    end
  endtask

  // Random traffic against a timestamp-based transaction model.
  task automatic test_random();
    bit            pend = 0, pown_d = 0, pdrop = 0;
    int            cap = 0, streak = 0;
    logic [DW-1:0] e_ifr = '0, e_dr = '0;
    bit            e_ifv = 0, e_dv = 0, e_busy = 0;
    bit            fok, starve, eg_d, eg_f;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    clr(); rst = 1'b1; tick(); rst = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      bus.if_req  = ($urandom_range(1, 0) == 1);
      bus.d_req   = ($urandom_range(1, 0) == 1);
      bus.d_we    = ($urandom_range(1, 0) == 1);
      bus.halt    = ($urandom_range(4, 0) == 0);
      bus.if_flush = ($urandom_range(6, 0) == 0);
      bus.if_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      bus.mem_rddata = $urandom;
      sample();
      fok = bus.if_req && !bus.halt && !bus.if_flush;
`ifdef STARVE_GUARD_EN
      starve = fok && (streak >= MS);
`else
      starve = 0;
`endif
      eg_d = !pend && bus.d_req && !starve;
      eg_f = !pend && !eg_d && fok;
      e_addr  = eg_d ? bus.d_addr : (eg_f ? bus.if_addr : '0);
      e_wdata = (eg_d && bus.d_we) ? bus.d_wdata : '0;
      vectors++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_wren, bus.mem_addr, bus.mem_wdata} !==
          {eg_f, eg_d, eg_d && bus.d_we, e_addr, e_wdata}) begin
        errors++; $display("FAIL rand_comb t%0d: ig=%b dg=%b wren=%b addr=%h wd=%h, want %b %b %b %h %h", t,
                           bus.if_gnt, bus.d_gnt, bus.mem_wren, bus.mem_addr, bus.mem_wdata,
                           eg_f, eg_d, eg_d && bus.d_we, e_addr, e_wdata);
      end
      vectors++;
      if ({bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !==
          {e_busy, e_ifv, e_dv, e_ifr, e_dr}) begin
        errors++; $display("FAIL rand_reg t%0d: busy=%b ifv=%b dv=%b ifr=%h dr=%h, want %b %b %b %h %h", t,
                           bus.busy, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata,
                           e_busy, e_ifv, e_dv, e_ifr, e_dr);
      end
      // advance model across the coming edge
      e_ifv = 0; e_dv = 0;
      if (pend) begin
        if (!pown_d && bus.if_flush) pdrop = 1;
        if (t == cap) begin
          if (pown_d) begin e_dr = bus.mem_rddata; e_dv = 1; end
          else if (!pdrop) begin e_ifr = bus.mem_rddata; e_ifv = 1; end
          pend = 0;
        end
      end
      if ((eg_d && !bus.d_we) || eg_f) begin
        pend = 1; pown_d = eg_d; cap = t + L; pdrop = 0;
      end
      e_busy = pend;
      if (eg_f || !bus.if_req) streak = 0;
      else if (eg_d && !bus.halt && streak < 15) streak++;
      tick();
    end
    clr();
  endtask

  initial begin
    rst = 1'b1; clr(); bus.mem_rddata = '0;
    test_reset();
    test_fetch_read();
    test_store_prio();
    test_flush();
    test_halt();
    test_streak();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
